// File: rtl/sim_exit_ctrl.sv
// Simulation-control slave on the peripheral OBI bus. Software writes its
// return code to EXIT; after a drain delay exit_valid_o/exit_value_o tell the
// testbench top to finish. Also provides a VCD dump trigger, a free-running
// 64-bit cycle counter and an optional cycle-limit timeout.
module sim_exit_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned EXIT_DELAY   = 16,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  dump_trigger_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StPending = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] OffExit    = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] OffDump    = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] OffCycleLo = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] OffCycleHi = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] OffTimeout = ADDR_WIDTH'(32'h10);

  localparam logic [7:0] DelayInit = 8'(EXIT_DELAY);

  logic [1:0]  state_q, state_d;
  logic [7:0]  delay_q, delay_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] timeout_q, timeout_d;
  logic        dump_q, dump_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt;
  logic        exit_acc;

  // Bus stalls once the exit has been signalled.
  assign gnt = req_i && (state_q != StDone);

  // Register access decode, response generation and exit FSM next state.
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    cnt_d        = cnt_q + 64'd1;
    hi_snap_d    = hi_snap_q;
    timeout_d    = timeout_q;
    dump_d       = dump_q;
    exit_value_d = exit_value_q;
    rvalid_d     = gnt;
    rdata_d      = 32'd0;
    err_d        = 1'b0;
    exit_acc     = 1'b0;

    if (gnt) begin
      case (addr_i)
        OffExit: begin
          if (we_i) begin
            if (be_i != 4'hF) begin
              err_d = 1'b1;
            end else if (state_q == StRun) begin
              exit_acc = 1'b1;
            end
          end
        end
        OffDump: begin
          if (we_i) begin
            if (be_i[0]) dump_d = wdata_i[0];
          end else begin
            rdata_d = {31'd0, dump_q};
          end
        end
        OffCycleLo: begin
          if (we_i) begin
            err_d = 1'b1;
          end else begin
            rdata_d   = cnt_q[31:0];
            // Snapshot HI now so a following HI read pairs with this LO value.
            hi_snap_d = cnt_q[63:32];
          end
        end
        OffCycleHi: begin
          if (we_i) err_d = 1'b1;
          else      rdata_d = hi_snap_q;
        end
        OffTimeout: begin
          if (we_i) begin
            for (int i = 0; i < 4; i++) begin
              if (be_i[i]) timeout_d[8*i +: 8] = wdata_i[8*i +: 8];
            end
          end else begin
            rdata_d = timeout_q;
          end
        end
        default: err_d = 1'b1;
      endcase
    end

    case (state_q)
      StRun: begin
        // A same-cycle EXIT write beats the timeout.
        if (exit_acc) begin
          exit_value_d = wdata_i;
          if (EXIT_DELAY == 0) begin
            state_d = StDone;
          end else begin
            state_d = StPending;
            delay_d = DelayInit;
          end
        end else if ((timeout_q != 32'd0) && (cnt_q[31:0] == timeout_q)) begin
          exit_value_d = TIMEOUT_CODE;
          state_d      = StDone;
        end
      end
      StPending: begin
        delay_d = delay_q - 8'd1;
        if (delay_q == 8'd1) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State and response registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      delay_q      <= 8'd0;
      cnt_q        <= 64'd0;
      hi_snap_q    <= 32'd0;
      timeout_q    <= 32'd0;
      dump_q       <= 1'b0;
      exit_value_q <= 32'd0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      cnt_q        <= cnt_d;
      hi_snap_q    <= hi_snap_d;
      timeout_q    <= timeout_d;
      dump_q       <= dump_d;
      exit_value_q <= exit_value_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign gnt_o          = gnt;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;
  assign dump_trigger_o = dump_q;
  assign exit_valid_o   = (state_q == StDone);
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Bench for sim_exit_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a time-based model.
module tb_sim_exit_ctrl;

  localparam int unsigned D     = 16;
  localparam logic [31:0] TCODE = 32'hDEAD_0001;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req;
  logic [4:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt_o, rvalid_o, err_o, dump_trigger_o, exit_valid_o;
  logic [31:0] rdata_o, exit_value_o;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int tb_cycles;

  sim_exit_ctrl #(
    .ADDR_WIDTH  (5),
    .EXIT_DELAY  (D),
    .TIMEOUT_CODE(TCODE)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .gnt_o         (gnt_o),
    .addr_i        (addr),
    .we_i          (we),
    .be_i          (be),
    .wdata_i       (wdata),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .dump_trigger_o(dump_trigger_o),
    .exit_valid_o  (exit_valid_o),
    .exit_value_o  (exit_value_o)
  );

  always #5 clk = ~clk;

  // Model: exit is described by the cycle it was scheduled for, not by states.
  logic [63:0] m_cyc, m_hi, m_exit_at, m_load_at;
  logic [31:0] m_to, m_code, m_rd;
  logic        m_dump, m_rv, m_err;
  bit          m_sched;
  logic        e_gnt, e_valid;
  logic [31:0] e_value;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_hi = 0; m_exit_at = 0; m_load_at = 0;
    m_to = 0; m_code = 0; m_rd = 0; m_dump = 0; m_rv = 0; m_err = 0; m_sched = 0;
    tb_cycles = 0;
  endtask

  function automatic bit m_done();
    return m_sched && (m_cyc >= m_exit_at);
  endfunction

  task automatic model_comb();
    e_valid = m_done();
    e_gnt   = req && !e_valid;
    e_value = (m_sched && m_cyc >= m_load_at) ? m_code : 32'd0;
  endtask

  task automatic model_step();
    bit          g, acc;
    logic        nrv, nerr;
    logic [31:0] nrd, to_old;
    if (!rst_ni) return;
    g = req && !m_done();
    acc = 0; nrv = 0; nerr = 0; nrd = 0; to_old = m_to;
    if (g) begin
      nrv = 1;
      case (addr)
        5'h00: if (we) begin
          if (be != 4'hF) nerr = 1;
          else if (!m_sched) acc = 1;
        end
        5'h04: if (we) begin
          if (be[0]) m_dump = wdata[0];
        end else nrd = {31'd0, m_dump};
        5'h08: if (we) nerr = 1;
               else begin nrd = m_cyc[31:0]; m_hi = {32'd0, m_cyc[63:32]}; end
        5'h0C: if (we) nerr = 1; else nrd = m_hi[31:0];
        5'h10: if (we) begin
          for (int i = 0; i < 4; i++) if (be[i]) m_to[8*i +: 8] = wdata[8*i +: 8];
        end else nrd = m_to;
        default: nerr = 1;
      endcase
    end
    if (acc) begin
      m_sched = 1; m_code = wdata; m_load_at = m_cyc + 1; m_exit_at = m_cyc + 1 + 64'(D);
    end else if (!m_sched && to_old != 0 && m_cyc[31:0] == to_old) begin
      m_sched = 1; m_code = TCODE; m_load_at = m_cyc + 1; m_exit_at = m_cyc + 1;
    end
    m_cyc++;
    tb_cycles++;
    m_rv = nrv; m_rd = nrd; m_err = nerr;
  endtask

  // Single compare point, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",        gnt_o,          e_gnt);
      check("rvalid",     rvalid_o,       m_rv);
      check("rdata",      rdata_o,        m_rd);
      check("err",        err_o,          m_err);
      check("dump",       dump_trigger_o, m_dump);
      check("exit_valid", exit_valid_o,   e_valid);
      check("exit_value", exit_value_o,   e_value);
    end
  end

  // One bus cycle: inputs applied just after the edge, model advanced on the edge.
  task automatic drive(input logic r, input logic [4:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; addr = a; we = w; be = b; wdata = d;
    model_comb();
    chk_en = 1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'h00, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    idle();
    idle();
    rst_ni = 1'b1;
  endtask

  task automatic wait_exit(input int max, output int n);
    n = 0;
    while (exit_valid_o !== 1'b1 && n < max) begin
      idle();
      n++;
    end
    check("exit_wait", exit_valid_o, 1'b1);
  endtask

  int n;
  int k;
  logic [4:0] ra;

  initial begin
    req = 0; addr = 0; we = 0; be = 0; wdata = 0; rst_ni = 1'b0;
    do_reset();

    // Cycle counter reads, 10 cycles apart.
    drive(1, 5'h08, 0, 4'hF, 0);
    check("cyc_lo_first", rdata_o, 32'd0);
    repeat (9) idle();
    drive(1, 5'h08, 0, 4'hF, 0);
    check("cyc_lo_second", rdata_o, 32'd10);
    drive(1, 5'h0C, 0, 4'hF, 0);
    check("cyc_hi", rdata_o, 32'd0);
    check("cyc_hi_err", err_o, 1'b0);

    // Dump trigger follows writes.
    drive(1, 5'h04, 1, 4'hF, 32'd1);
    check("dump_set", dump_trigger_o, 1'b1);
    drive(1, 5'h04, 1, 4'hF, 32'd0);
    check("dump_clr", dump_trigger_o, 1'b0);

    // Unmapped offset and partial EXIT write.
    drive(1, 5'h14, 0, 4'hF, 0);
    check("bad_off_err", err_o, 1'b1);
    check("bad_off_rdata", rdata_o, 32'd0);
    drive(1, 5'h00, 1, 4'h3, 32'h55);
    check("exit_be_err", err_o, 1'b1);
    repeat (20) idle();
    check("exit_be_ignored", exit_valid_o, 1'b0);

    // EXIT 0: latency from grant to exit_valid.
    drive(1, 5'h00, 1, 4'hF, 32'd0);
    wait_exit(100, n);
    check("exit_latency", n + 1, 17);
    check("exit_value0", exit_value_o, 32'd0);
    req = 1; #1;
    check("gnt_done", gnt_o, 1'b0);
    drive(1, 5'h04, 1, 4'hF, 32'd1);

    // First code wins.
    do_reset();
    drive(1, 5'h00, 1, 4'hF, 32'd5);
    repeat (3) idle();
    drive(1, 5'h00, 1, 4'hF, 32'd9);
    check("second_exit_rvalid", rvalid_o, 1'b1);
    check("second_exit_err", err_o, 1'b0);
    wait_exit(100, n);
    check("first_code_wins", exit_value_o, 32'd5);

    // Timeout fires.
    do_reset();
    drive(1, 5'h10, 1, 4'hF, 32'd200);
    wait_exit(400, n);
    check("timeout_value", exit_value_o, TCODE);
    check("timeout_cycle", tb_cycles, 201);

    // EXIT coincident with timeout match.
    do_reset();
    drive(1, 5'h10, 1, 4'hF, 32'd50);
    while (tb_cycles < 50) idle();
    drive(1, 5'h00, 1, 4'hF, 32'd7);
    wait_exit(100, n);
    check("coincident_value", exit_value_o, 32'd7);
    check("coincident_cycle", tb_cycles, 67);

    // Asynchronous reset mid-PENDING.
    do_reset();
    drive(1, 5'h04, 1, 4'hF, 32'd1);
    drive(1, 5'h00, 1, 4'hF, 32'd1);
    repeat (4) idle();
    #2;
    rst_ni = 1'b0;
    model_reset();
    model_comb();
    #1;
    check("arst_valid",  exit_valid_o,   1'b0);
    check("arst_value",  exit_value_o,   32'd0);
    check("arst_dump",   dump_trigger_o, 1'b0);
    check("arst_rvalid", rvalid_o,       1'b0);
    check("arst_rdata",  rdata_o,        32'd0);
    check("arst_err",    err_o,          1'b0);
    check("arst_gnt",    gnt_o,          1'b0);
    idle();
    idle();
    rst_ni = 1'b1;
    drive(1, 5'h00, 1, 4'hF, 32'd3);
    wait_exit(100, n);
    check("post_arst_latency", n + 1, 17);
    check("post_arst_value", exit_value_o, 32'd3);

    // Randomized traffic.
    for (int seg = 0; seg < 15; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        k = $urandom_range(0, 15);
        case (k)
          0:           ra = 5'h00;
          1, 2, 3:     ra = 5'h04;
          4, 5:        ra = 5'h08;
          6, 7:        ra = 5'h0C;
          8, 9, 10:    ra = 5'h10;
          11:          ra = 5'h14;
          12:          ra = 5'($urandom_range(0, 31));
          default:     ra = 5'h04;
        endcase
        drive(($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
              (ra == 5'h10) ? 32'($urandom_range(0, 400)) : $urandom);
      end
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
